// File: rtl/core_wb_pipe_if.sv
// Bundle between the execute stage (master) and the writeback pipeline (slave):
// the stage-control, incoming-result, commit, forwarding and occupancy signals.
interface core_wb_pipe_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PCW   = 32,
  parameter int DEPTH = 2,
  parameter int NRD   = 2
);
  logic                         halt;
  logic                         flush;
  logic                         in_wb;
  logic [AW-1:0]                in_addr;
  logic [DW-1:0]                in_data;
  logic [PCW-1:0]               in_pc;
  logic                         wb;
  logic [AW-1:0]                wb_addr;
  logic [DW-1:0]                wb_data;
  logic [PCW-1:0]               wb_pc;
  logic [NRD*AW-1:0]            rd_addr;
  logic [NRD-1:0]               fwd_hit;
  logic [NRD*DW-1:0]            fwd_data;
  logic [$clog2(DEPTH+1)-1:0]   occ;

  modport master (
    output halt, flush, in_wb, in_addr, in_data, in_pc, rd_addr,
    input  wb, wb_addr, wb_data, wb_pc, fwd_hit, fwd_data, occ
  );

  modport slave (
    input  halt, flush, in_wb, in_addr, in_data, in_pc, rd_addr,
    output wb, wb_addr, wb_data, wb_pc, fwd_hit, fwd_data, occ
  );
endinterface

// File: rtl/core_wb_pipe.sv
// Writeback pipeline: DEPTH result stages, commit from the oldest, operand forwarding.
// Optional macro I2D_WB_PIPE_IN_BYPASS_EN also forwards the incoming result.
module core_wb_pipe #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PCW   = 32,
  parameter int DEPTH = 2,
  parameter int NRD   = 2
) (
  input  logic            clk,
  input  logic            rst,
  core_wb_pipe_if.slave   bus
);
  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]          vld_q,  vld_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0]  data_q, data_d;
  logic [DEPTH-1:0][PCW-1:0] pc_q,   pc_d;
  logic [OW-1:0]             occ_q,  occ_d;
  logic [NRD-1:0]            fwd_hit_s;
  logic [NRD*DW-1:0]         fwd_data_s;

  function automatic logic [OW-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + OW'(v[i]);
    end
    return c;
  endfunction

  // Next stage contents: flush clears, halt holds, otherwise shift toward commit.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (bus.flush) begin
      vld_d  = '0;
      addr_d = '0;
      data_d = '0;
      pc_d   = '0;
    end else if (!bus.halt) begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
        data_d[i] = data_q[i-1];
        pc_d[i]   = pc_q[i-1];
      end
      // Bubbles carry zeroed fields so commit outputs stay zero without extra gating.
      vld_d[0]  = bus.in_wb;
      addr_d[0] = bus.in_wb ? bus.in_addr : {AW{1'b0}};
      data_d[0] = bus.in_wb ? bus.in_data : {DW{1'b0}};
      pc_d[0]   = bus.in_wb ? bus.in_pc   : {PCW{1'b0}};
    end else begin
      vld_d = vld_q;
    end
    occ_d = count_valid(vld_d);
  end

  // Stage registers and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      pc_q   <= '0;
      occ_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
      pc_q   <= pc_d;
      occ_q  <= occ_d;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_hit_s  = '0;
    fwd_data_s = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (vld_q[i] && (addr_q[i] == bus.rd_addr[p*AW +: AW])) begin
          fwd_hit_s[p]           = 1'b1;
          fwd_data_s[p*DW +: DW] = data_q[i];
        end else begin
          fwd_hit_s[p]           = fwd_hit_s[p];
        end
      end
`ifdef I2D_WB_PIPE_IN_BYPASS_EN
      if (bus.in_wb && !bus.flush && (bus.in_addr == bus.rd_addr[p*AW +: AW])) begin
        fwd_hit_s[p]           = 1'b1;
        fwd_data_s[p*DW +: DW] = bus.in_data;
      end else begin
        fwd_hit_s[p]           = fwd_hit_s[p];
      end
`endif
    end
  end

  // A flush still lets the oldest result commit; halt suppresses it until released.
  assign bus.wb       = vld_q[DEPTH-1] & (~bus.halt | bus.flush);
  assign bus.wb_addr  = vld_q[DEPTH-1] ? addr_q[DEPTH-1] : {AW{1'b0}};
  assign bus.wb_data  = vld_q[DEPTH-1] ? data_q[DEPTH-1] : {DW{1'b0}};
  assign bus.wb_pc    = vld_q[DEPTH-1] ? pc_q[DEPTH-1]   : {PCW{1'b0}};
  assign bus.fwd_hit  = fwd_hit_s;
  assign bus.fwd_data = fwd_data_s;
  assign bus.occ      = occ_q;
endmodule
